// File: rtl/gelu_lut.sv
// Q4.4 GELU (exact erf form) as a 256-entry ROM, rounded to nearest with ties away from zero.
// One-cycle registered output, accepts a new code every clock with no stall; reset clears y_out asynchronously.
module gelu_lut #(
   parameter int FRAC_BITS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [2*FRAC_BITS-1:0] x_in,
   output logic [2*FRAC_BITS-1:0] y_out
);

   localparam int W = 2 * FRAC_BITS;

   logic signed [W-1:0] x_s;
   logic        [W-1:0] y_d;
   logic        [W-1:0] y_q;

   assign x_s = signed'(x_in);

   // Only codes -35..35 differ from the trivial tails; below -35 the product rounds
   // to zero and above 35 the deviation from identity is under half an LSB.
   always_comb begin
      y_d = '0;
      case (x_s)
         -8'sd35, -8'sd34, -8'sd33, -8'sd32, -8'sd31, -8'sd30,
         -8'sd29, -8'sd28, -8'sd27, -8'sd26, -8'sd25:          y_d = -8'sd1;
         -8'sd24, -8'sd23, -8'sd22, -8'sd21,
         -8'sd20, -8'sd19, -8'sd18, -8'sd17:                   y_d = -8'sd2;
         -8'sd16, -8'sd15, -8'sd14, -8'sd13,
         -8'sd12, -8'sd11, -8'sd10, -8'sd9:                    y_d = -8'sd3;
         -8'sd8, -8'sd7, -8'sd6, -8'sd5, -8'sd4:               y_d = -8'sd2;
         -8'sd3, -8'sd2:                                       y_d = -8'sd1;
         -8'sd1, 8'sd0:                                        y_d = 8'sd0;
         8'sd1, 8'sd2:                                         y_d = 8'sd1;
         8'sd3, 8'sd4:                                         y_d = 8'sd2;
         8'sd5:                                                y_d = 8'sd3;
         8'sd6:                                                y_d = 8'sd4;
         8'sd7:                                                y_d = 8'sd5;
         8'sd8, 8'sd9:                                         y_d = 8'sd6;
         8'sd10:                                               y_d = 8'sd7;
         8'sd11:                                               y_d = 8'sd8;
         8'sd12:                                               y_d = 8'sd9;
         8'sd13:                                               y_d = 8'sd10;
         8'sd14:                                               y_d = 8'sd11;
         8'sd15:                                               y_d = 8'sd12;
         8'sd16:                                               y_d = 8'sd13;
         8'sd17:                                               y_d = 8'sd15;
         8'sd18:                                               y_d = 8'sd16;
         8'sd19:                                               y_d = 8'sd17;
         8'sd20:                                               y_d = 8'sd18;
         8'sd21:                                               y_d = 8'sd19;
         8'sd22:                                               y_d = 8'sd20;
         8'sd23:                                               y_d = 8'sd21;
         8'sd24:                                               y_d = 8'sd22;
         8'sd25:                                               y_d = 8'sd24;
         8'sd26:                                               y_d = 8'sd25;
         8'sd27:                                               y_d = 8'sd26;
         8'sd28:                                               y_d = 8'sd27;
         8'sd29:                                               y_d = 8'sd28;
         8'sd30:                                               y_d = 8'sd29;
         8'sd31:                                               y_d = 8'sd30;
         8'sd32:                                               y_d = 8'sd31;
         8'sd33:                                               y_d = 8'sd32;
         8'sd34:                                               y_d = 8'sd33;
         8'sd35:                                               y_d = 8'sd34;
         default:                                              y_d = (x_s > 8'sd35) ? x_in : '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_q <= '0;
      end else begin
         y_q <= y_d;
      end
   end

   assign y_out = y_q;

endmodule

// File: tb/tb_gelu_lut.sv
// Bench for gelu_lut: golden table from numerically integrated normal CDF,
// directed reset/latency/tail steps followed by a full sweep and random codes.
module tb_gelu_lut;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] x_in;
   logic [7:0] y_out;

   int checks = 0;
   int errors = 0;
   int golden [256];

   int lat_x [4] = '{8, -8, 32, -32};
   int lat_y [4] = '{6, -2, 31, -1};
   int spot_x [13] = '{-128, -64, -40, -32, -16, -8, 0, 8, 16, 32, 36, 48, 64};
   int spot_y [13] = '{0, 0, 0, -1, -3, -2, 0, 6, 13, 31, 36, 48, 64};
   int tail_x [2] = '{100, 127};

   gelu_lut #(.FRAC_BITS(4)) dut (
      .clk   (clk),
      .reset (reset),
      .x_in  (x_in),
      .y_out (y_out)
   );

   always #5 clk = ~clk;

   // Phi(x) = 0.5 + integral_0^x of the normal density, composite Simpson rule.
   function automatic real phi(input real x);
      int  n = 512;
      real h, s, t, w;
      h = x / real'(n);
      s = 0.0;
      for (int k = 0; k <= n; k++) begin
         t = real'(k) * h;
         if (k == 0 || k == n) w = 1.0;
         else if (k % 2 == 1) w = 4.0;
         else w = 2.0;
         s = s + w * $exp(-t * t / 2.0);
      end
      return 0.5 + (s * h / 3.0) / $sqrt(2.0 * 3.14159265358979);
   endfunction

   function automatic int gelu_code(input int c);
      real v, r;
      int  ri;
      v = real'(c) * phi(real'(c) / 16.0);
      if (v >= 0.0) r = $floor(v + 0.5);
      else          r = -$floor(-v + 0.5);
      ri = $rtoi(r);
      if (ri > 127)  ri = 127;
      if (ri < -128) ri = -128;
      return ri;
   endfunction

   function automatic logic [7:0] gold(input int c);
      return 8'(golden[c + 128]);
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp_v));
      end
   endtask

   initial begin
      int rc;
      logic [7:0] prev;

      for (int c = -128; c <= 127; c++) golden[c + 128] = gelu_code(c);

      // reset held with a live input: output must stay at zero
      reset = 1'b1;
      x_in  = 8'd16;
      #1;
      check("reset_initial", y_out, 8'd0);
      repeat (4) begin
         @(posedge clk); #1;
         check("reset_hold", y_out, 8'd0);
      end
      @(negedge clk) reset = 1'b0;
      #1 check("reset_release_pre_edge", y_out, 8'd0);
      @(posedge clk); #1;
      check("reset_release_first_edge", y_out, 8'd13);

      // asynchronous reset between edges
      x_in = 8'd32;
      @(posedge clk); #1;
      check("async_pre", y_out, 8'd31);
      #2 reset = 1'b1;
      #1 check("async_reset_immediate", y_out, 8'd0);
      @(negedge clk) reset = 1'b0;
      #1 check("async_reset_held_to_edge", y_out, 8'd0);
      @(posedge clk); #1;
      check("async_reset_reload", y_out, 8'd31);

      // full sweep, one code per cycle
      for (int c = -128; c <= 127; c++) begin
         x_in = 8'(c);
         @(posedge clk); #1;
         check($sformatf("sweep x=%0d", c), y_out, gold(c));
      end

      // back-to-back codes: output holds until the edge, then updates exactly once
      prev = gold(127);
      for (int i = 0; i < 4; i++) begin
         x_in = 8'(lat_x[i]);
         #3 check($sformatf("latency_hold x=%0d", lat_x[i]), y_out, prev);
         @(posedge clk); #1;
         check($sformatf("latency x=%0d", lat_x[i]), y_out, 8'(lat_y[i]));
         prev = 8'(lat_y[i]);
      end

      // spot values and tails
      for (int i = 0; i < 13; i++) begin
         x_in = 8'(spot_x[i]);
         @(posedge clk); #1;
         check($sformatf("spot x=%0d", spot_x[i]), y_out, 8'(spot_y[i]));
      end
      for (int i = 0; i < 2; i++) begin
         x_in = 8'(tail_x[i]);
         @(posedge clk); #1;
         check($sformatf("tail_identity x=%0d", tail_x[i]), y_out, 8'(tail_x[i]));
      end

      // random codes with an occasional mid-stream reset
      for (int i = 0; i < 400; i++) begin
         rc   = int'($urandom_range(0, 255)) - 128;
         x_in = 8'(rc);
         @(posedge clk); #1;
         check($sformatf("random x=%0d", rc), y_out, gold(rc));
         if (i % 97 == 50) begin
            #2 reset = 1'b1;
            #1 check("random_async_reset", y_out, 8'd0);
            @(negedge clk) reset = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
